axi_lite_sram: RTL

- Single-port AXI4-Lite-style memory responder sitting on the memory side of the IFU/LSU arbiter; terminates `mem_*` AR/R/AW/W/B traffic.
- Holds a word-addressed array with byte-strobed writes and configurable response latency.
- Serves exactly one outstanding transaction at a time, matching the arbiter's single-transaction contract.

---
 rtl/axi_lite_sram.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_sram.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram
// Brief    : Single-outstanding AXI4-Lite-style SRAM responder. It provides a
//            word-addressed array with byte-strobed writes, SLVERR for
//            out-of-range addresses and LAT extra response wait cycles.
// Option   : SRAM_RAND_DELAY_EN adds LFSR-driven random latency (0..3 extra
//            cycles) and random ready back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int unsigned c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_span   = 32'(4 * DEPTH);
    localparam logic [4:0]  c_lat    = 5'(LAT);
    localparam logic [1:0]  c_okay   = 2'b00;
    localparam logic [1:0]  c_slverr = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_WAIT    = 3'd1,
        S_RD_RESP    = 3'd2,
        S_WR_COLLECT = 3'd3,
        S_WR_WAIT    = 3'd4,
        S_WR_RESP    = 3'd5
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t      state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q,  w_got_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [1:0]  rresp_q,  rresp_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q,  bresp_d;

    logic        rd_done;
    logic        wr_done;
    logic        mem_we;

    logic        w_gate;
    logic [4:0]  w_load;

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0]  lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8/6/5/4, free-running
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // LFSR state register
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_gate = ~lfsr_q[7];
    assign w_load = c_lat + {3'b000, lfsr_q[1:0]};
`else
    assign w_gate = 1'b1;
    assign w_load = c_lat;
`endif

    // Handshake readiness: writes may be collected in IDLE/WR_COLLECT,
    // reads are only taken from a fully idle bus so that a write wins.
    logic w_idle, w_accepting;
    logic w_aw_fire, w_w_fire, w_ar_fire;
    logic w_aw_have, w_w_have;

    assign w_idle      = (state_q == S_IDLE);
    assign w_accepting = w_idle || (state_q == S_WR_COLLECT);
    assign awready     = w_accepting && !aw_got_q && w_gate;
    assign wready      = w_accepting && !w_got_q && w_gate;
    assign arready     = w_idle && !awvalid && !wvalid && w_gate;
    assign w_aw_fire   = awvalid && awready;
    assign w_w_fire    = wvalid && wready;
    assign w_ar_fire   = arvalid && arready;
    assign w_aw_have   = aw_got_q || w_aw_fire;
    assign w_w_have    = w_got_q || w_w_fire;

    // Effective transaction operands at completion time. A read completing
    // straight from IDLE (LAT=0) uses the live address; a write uses the
    // live channel for whichever half has not been latched yet.
    logic [31:0]        w_rd_addr, w_rd_off;
    logic [31:0]        w_wr_addr, w_wr_off, w_wr_data;
    logic [3:0]         w_wr_strb;
    logic               w_rd_ok, w_wr_ok;
    logic [c_idx_w-1:0] w_rd_idx, w_wr_idx;

    assign w_rd_addr = w_idle ? araddr : araddr_q;
    assign w_wr_addr = aw_got_q ? awaddr_q : awaddr;
    assign w_wr_data = w_got_q ? wdata_q : wdata;
    assign w_wr_strb = w_got_q ? wstrb_q : wstrb;
    assign w_rd_off  = w_rd_addr - BASE;
    assign w_wr_off  = w_wr_addr - BASE;
    assign w_rd_ok   = (w_rd_addr >= BASE) && (w_rd_off < c_span);
    assign w_wr_ok   = (w_wr_addr >= BASE) && (w_wr_off < c_span);
    assign w_rd_idx  = w_rd_off[c_idx_w+1:2];
    assign w_wr_idx  = w_wr_off[c_idx_w+1:2];

    // Next-state and response computation for the transaction FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        araddr_d = araddr_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        mem_we   = 1'b0;

        unique case (state_q)
            S_IDLE, S_WR_COLLECT: begin
                if (w_aw_fire) begin
                    aw_got_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (w_w_fire) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if (w_aw_have && w_w_have) begin
                    if (w_load == 5'd0) begin
                        state_d = S_WR_RESP;
                        wr_done = 1'b1;
                    end else begin
                        state_d = S_WR_WAIT;
                        cnt_d   = w_load;
                    end
                end else if (w_aw_fire || w_w_fire) begin
                    state_d = S_WR_COLLECT;
                end else if (w_ar_fire) begin
                    araddr_d = araddr;
                    if (w_load == 5'd0) begin
                        state_d = S_RD_RESP;
                        rd_done = 1'b1;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = w_load;
                    end
                end
            end
            S_RD_WAIT: begin
                cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                if (cnt_q <= 5'd1) begin
                    state_d = S_RD_RESP;
                    rd_done = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (rready) begin
                    state_d  = S_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            S_WR_WAIT: begin
                cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                if (cnt_q <= 5'd1) begin
                    state_d = S_WR_RESP;
                    wr_done = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (bready) begin
                    state_d  = S_IDLE;
                    bvalid_d = 1'b0;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rd_done) begin
            rvalid_d = 1'b1;
            rresp_d  = w_rd_ok ? c_okay : c_slverr;
            rdata_d  = w_rd_ok ? mem[w_rd_idx] : 32'h0;
        end
        if (wr_done) begin
            bvalid_d = 1'b1;
            bresp_d  = w_wr_ok ? c_okay : c_slverr;
            mem_we   = w_wr_ok;
        end
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            araddr_q <= 32'h0;
            awaddr_q <= 32'h0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= c_okay;
            bvalid_q <= 1'b0;
            bresp_q  <= c_okay;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            araddr_q <= araddr_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    // Byte-strobed array write; a reset in the same cycle drops the write
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_strb[b]) begin
                    mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;

endmodule
`default_nettype wire
